// File: rtl/imem_uart_loader.sv
// imem_uart_loader: receives 8N1 UART bytes, packs them little-endian into 32-bit words
// and writes them sequentially into instruction memory while load_en_i is high.
module imem_uart_loader #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              uart_rx_i,
    input  logic              load_en_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wd_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic              byte_ok, ferr_set;
    logic [1:0]        lane_q;
    logic [23:0]       word_q;
    logic [ADDR_W-1:0] addr_q, im_addr_q;
    logic [ADDR_W:0]   wcnt_q;
    logic [31:0]       im_wd_q;
    logic              we_q, done_q, ferr_q;

    // A start needs a falling edge, so a frame already mid-flight at enable is ignored
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        sh_d     = sh_q;
        byte_ok  = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s2_q && rx_prev_q) state_d = START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {rx_s2_q, sh_q[7:1]};
                bit_d = bit_q + 3'(1);
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (cnt_q == FULL) begin
                cnt_d    = '0;
                byte_ok  = rx_s2_q;
                ferr_set = !rx_s2_q;
                state_d  = rx_s2_q ? IDLE : WAIT_HI;
            end
            WAIT_HI: begin
                cnt_d = '0;
                if (rx_s2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!load_en_i) begin
            state_d  = IDLE;
            byte_ok  = 1'b0;
            ferr_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            lane_q    <= '0;
            word_q    <= '0;
            addr_q    <= '0;
            wcnt_q    <= '0;
            we_q      <= 1'b0;
            im_addr_q <= '0;
            im_wd_q   <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_s1_q   <= uart_rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            we_q      <= 1'b0;
            if (!load_en_i) begin
                lane_q <= '0;
                addr_q <= '0;
                wcnt_q <= '0;
                done_q <= 1'b0;
                ferr_q <= 1'b0;
            end else begin
                if (ferr_set) ferr_q <= 1'b1;
                if (byte_ok && !done_q) begin
                    lane_q <= lane_q + 2'(1);
                    word_q <= {sh_q, word_q[23:8]};
                    if (lane_q == 2'd3) begin
                        we_q      <= 1'b1;
                        im_addr_q <= addr_q;
                        im_wd_q   <= {sh_q, word_q};
                    end
                end
                // Counters advance as the strobe ends
                if (we_q) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    wcnt_q <= wcnt_q + (ADDR_W + 1)'(1);
                    if (wcnt_q + (ADDR_W + 1)'(1) == (ADDR_W + 1)'(DEPTH)) done_q <= 1'b1;
                end
            end
        end
    end

    assign im_we_o     = we_q;
    assign im_addr_o   = im_addr_q;
    assign im_wd_o     = im_wd_q;
    assign word_cnt_o  = wcnt_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: directed UART frames into the loader, checking IM writes,
// counters and status flags against hand-computed values.
module tb_imem_uart_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0, rstn = 1'b0, rx = 1'b1, en = 1'b0;
    logic        we, busy, done, ferr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [2:0]  wcnt;

    always #5 clk = ~clk;

    imem_uart_loader #(.CLK_HZ(16), .BAUD(1), .ADDR_W(2), .DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .uart_rx_i(rx), .load_en_i(en),
        .im_we_o(we), .im_addr_o(addr), .im_wd_o(wd), .word_cnt_o(wcnt),
        .busy_o(busy), .done_o(done), .frame_err_o(ferr)
    );

    typedef struct packed {logic [1:0] a; logic [31:0] d;} wr_t;
    typedef struct packed {logic [31:0] w; logic [1:0] a; logic [2:0] cnt; logic dn;} vec_t;

    wr_t  wq[$];
    vec_t tbl[4];
    int   checks = 0, errors = 0, long_pulse = 0;
    logic we_prev = 1'b0;

    // Record each strobe's rising cycle; a strobe high two samples in a row is an error
    always @(negedge clk) begin
        if (we && !we_prev) wq.push_back('{addr, wd});
        if (we && we_prev) long_pulse++;
        we_prev <= we;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic expect_write(input string n, input logic [1:0] a, input logic [31:0] d);
        wr_t w;
        checks++;
        if (wq.size() != 1) begin
            errors++;
            $display("FAIL %s: %0d writes seen, want 1", n, wq.size());
            wq.delete();
        end else begin
            w = wq.pop_front();
            chk({n, ".addr"}, 32'(w.a), 32'(a));
            chk({n, ".wd"}, w.d, d);
        end
    endtask

    task automatic expect_none(input string n);
        chk(n, 32'(wq.size()), 0);
        wq.delete();
    endtask

    task automatic clear_session();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        wq.delete();
    endtask

    initial begin
        tbl[0] = '{32'h11223344, 2'd0, 3'd1, 1'b0};
        tbl[1] = '{32'hA5A55A5A, 2'd1, 3'd2, 1'b0};
        tbl[2] = '{32'h00000001, 2'd2, 3'd3, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 2'd3, 3'd4, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst.we", 32'(we), 0);
        chk("rst.addr", 32'(addr), 0);
        chk("rst.wd", wd, 0);
        chk("rst.cnt", 32'(wcnt), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.ferr", 32'(ferr), 0);
        rstn = 1'b1;
        en = 1'b1;
        repeat (4) @(negedge clk);

        send_word(32'h00500513);
        expect_write("t1", 2'd0, 32'h00500513);
        chk("t1.cnt", 32'(wcnt), 1);
        chk("t1.done", 32'(done), 0);
        chk("t1.addr_hold", 32'(addr), 0);

        clear_session();
        chk("t2.cnt_clr", 32'(wcnt), 0);
        for (int i = 0; i < 4; i++) begin
            send_word(tbl[i].w);
            expect_write($sformatf("t2.w%0d", i), tbl[i].a, tbl[i].w);
            chk($sformatf("t2.cnt%0d", i), 32'(wcnt), 32'(tbl[i].cnt));
            chk($sformatf("t2.done%0d", i), 32'(done), 32'(tbl[i].dn));
        end
        send_word(32'hCAFEBABE);
        expect_none("t2.drop");
        chk("t2.cnt_full", 32'(wcnt), 4);
        chk("t2.addr_stay", 32'(addr), 3);
        chk("t2.done_sticky", 32'(done), 1);

        clear_session();
        chk("t3.done_clr", 32'(done), 0);
        send_byte(8'h01);
        send_byte(8'h02);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3.busy_start", 32'(busy), 1);
        repeat (30) @(negedge clk);
        chk("t3.busy_drop", 32'(busy), 0);
        expect_none("t3.no_byte");
        send_byte(8'h03);
        send_byte(8'h04);
        expect_write("t3", 2'd0, 32'h04030201);

        clear_session();
        send_byte(8'h77, 1'b0);
        chk("t4.ferr", 32'(ferr), 1);
        chk("t4.busy", 32'(busy), 0);
        expect_none("t4.discard");
        send_word(32'h12345678);
        expect_write("t4", 2'd0, 32'h12345678);
        chk("t4.ferr_sticky", 32'(ferr), 1);
        clear_session();
        chk("t4.ferr_clr", 32'(ferr), 0);

        send_byte(8'h11);
        send_byte(8'h22);
        clear_session();
        send_word(32'hDEADBEEF);
        expect_write("t5", 2'd0, 32'hDEADBEEF);
        chk("t5.cnt", 32'(wcnt), 1);

        rx = 1'b0;
        repeat (50) @(negedge clk);
        chk("t6.busy_pre", 32'(busy), 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6.we", 32'(we), 0);
        chk("t6.addr", 32'(addr), 0);
        chk("t6.wd", wd, 0);
        chk("t6.cnt", 32'(wcnt), 0);
        chk("t6.busy", 32'(busy), 0);
        chk("t6.done", 32'(done), 0);
        chk("t6.ferr", 32'(ferr), 0);
        rx = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        wq.delete();
        send_word(32'hA1B2C3D4);
        expect_write("t6", 2'd0, 32'hA1B2C3D4);

        chk("we_one_cycle", 32'(long_pulse), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
